// File: rtl/vregfile_pkg.sv
// Shared types, default sizes and lane-merge helper for the vector register file.
package vregfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int unsigned DEF_NREGS  = 32;
    localparam int unsigned DEF_LANES  = 4;
    localparam int unsigned DEF_LANE_W = 32;

    // Upper bounds for the width-generic merge helper.
    localparam int unsigned MAX_REG_W = 1024;
    localparam int unsigned MAX_LANES = 64;

    // Merge a write into the old register value. Bit b belongs to lane b/lane_w.
    // Masked lanes take either their own lane of new_val or, in broadcast
    // mode, lane 0 of new_val. Unmasked lanes keep old_val.
    function automatic logic [MAX_REG_W-1:0] lane_merge(
        input logic [MAX_REG_W-1:0] old_val,
        input logic [MAX_REG_W-1:0] new_val,
        input logic [MAX_LANES-1:0] mask,
        input logic                 bcast,
        input int unsigned          lanes,
        input int unsigned          lane_w
    );
        logic [MAX_REG_W-1:0] res;
        int unsigned          lane_idx;
        int unsigned          src_idx;
        res = old_val;
        for (int unsigned b = 0; b < MAX_REG_W; b++) begin
            if (b < lanes * lane_w) begin
                lane_idx = b / lane_w;
                src_idx  = bcast ? (b % lane_w) : b;
                if (mask[lane_idx]) begin
                    res[b] = new_val[src_idx];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vregfile_clear_seq.sv
// Bulk-clear sequencer: walks registers 1..NREGS-1, one per falling edge.
module vregfile_clear_seq
    import vregfile_pkg::*;
#(
    parameter  int unsigned NREGS = DEF_NREGS,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_req_i,
    output logic          busy_o,
    output logic          clear_done_o,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_addr_o
);

    localparam logic [AW-1:0] FIRST_ADDR = AW'(1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(NREGS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // State, counter and done pulse register; all updates on the falling edge.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= FIRST_ADDR;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: start on request, step the counter, finish on the last register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = FIRST_ADDR;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = FIRST_ADDR;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = FIRST_ADDR;
            end
        endcase
    end

    assign busy_o       = (state_q == CLEAR);
    assign clr_en_o     = (state_q == CLEAR);
    assign clr_addr_o   = cnt_q;
    assign clear_done_o = done_q;

endmodule

// File: rtl/vector_regfile_lanes.sv
// Lane-masked vector register file with broadcast writes and bulk clear.
module vector_regfile_lanes
    import vregfile_pkg::*;
#(
    parameter  int unsigned NREGS  = DEF_NREGS,
    parameter  int unsigned LANES  = DEF_LANES,
    parameter  int unsigned LANE_W = DEF_LANE_W,
    parameter  int unsigned NREAD  = 2,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                          clock,
    input  logic                          async_reset,
    input  logic                          write_enable,
    input  logic [AW-1:0]                 write_addr,
    input  logic [LANES-1:0]              write_mask,
    input  logic                          write_broadcast,
    input  logic [LANES*LANE_W-1:0]       write_data,
    input  logic [NREAD*AW-1:0]           read_addr,
    output logic [NREAD*LANES*LANE_W-1:0] read_data,
    input  logic                          clear_req,
    output logic                          busy,
    output logic                          clear_done,
    output logic                          write_dropped
);

    localparam int unsigned REG_W   = LANES * LANE_W;
    localparam logic [AW:0] NREGS_X = (AW + 1)'(NREGS);

    logic [REG_W-1:0] regs_q [NREGS];
    logic [REG_W-1:0] regs_d [NREGS];
    logic [REG_W-1:0] merged;
    logic             clr_en;
    logic [AW-1:0]    clr_addr;
    logic             wr_accept;

    vregfile_clear_seq #(
        .NREGS (NREGS)
    ) u_clear_seq (
        .clk_i        (clock),
        .rst_ni       (async_reset),
        .clear_req_i  (clear_req),
        .busy_o       (busy),
        .clear_done_o (clear_done),
        .clr_en_o     (clr_en),
        .clr_addr_o   (clr_addr)
    );

    assign wr_accept = write_enable && (write_addr != '0) && ({1'b0, write_addr} < NREGS_X)
                       && !busy && !clear_req;

    assign write_dropped = write_enable && (busy || clear_req);

    // Merged value for the addressed register (helper works on padded vectors).
    always_comb begin
        merged = REG_W'(lane_merge(MAX_REG_W'(regs_q[write_addr]), MAX_REG_W'(write_data),
                                   MAX_LANES'(write_mask), write_broadcast, LANES, LANE_W));
    end

    // Next contents: clear step has priority; a write cannot coincide since busy blocks it.
    always_comb begin
        regs_d = regs_q;
        if (clr_en) begin
            regs_d[clr_addr] = '0;
        end else if (wr_accept) begin
            regs_d[write_addr] = merged;
        end
    end

    // Register storage, updated on the falling edge; entry 0 is never written.
    always_ff @(negedge clock or negedge async_reset) begin
        if (!async_reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports; address 0 and out-of-range addresses return zero.
    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0] raddr;
        assign raddr = read_addr[p*AW +: AW];
        assign read_data[p*REG_W +: REG_W] =
            ((raddr != '0) && ({1'b0, raddr} < NREGS_X)) ? regs_q[raddr] : '0;
    end

endmodule

// File: tb/tb_vector_regfile_lanes.sv
// Directed bench for vector_regfile_lanes with an array/queue reference model.
module tb_vector_regfile_lanes;

    localparam int NREGS  = 32;
    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int NREAD  = 2;
    localparam int AW     = 5;
    localparam int REG_W  = LANES * LANE_W;

    logic                     clock = 1'b1;
    logic                     async_reset;
    logic                     write_enable;
    logic [AW-1:0]            write_addr;
    logic [LANES-1:0]         write_mask;
    logic                     write_broadcast;
    logic [REG_W-1:0]         write_data;
    logic [NREAD*AW-1:0]      read_addr;
    logic [NREAD*REG_W-1:0]   read_data;
    logic                     clear_req;
    logic                     busy;
    logic                     clear_done;
    logic                     write_dropped;

    int n_cmp = 0;
    int n_err = 0;
    bit check_on = 1'b0;

    vector_regfile_lanes #(
        .NREGS  (NREGS),
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .NREAD  (NREAD)
    ) dut (
        .clock           (clock),
        .async_reset     (async_reset),
        .write_enable    (write_enable),
        .write_addr      (write_addr),
        .write_mask      (write_mask),
        .write_broadcast (write_broadcast),
        .write_data      (write_data),
        .read_addr       (read_addr),
        .read_data       (read_data),
        .clear_req       (clear_req),
        .busy            (busy),
        .clear_done      (clear_done),
        .write_dropped   (write_dropped)
    );

    always #5 clock = ~clock;

    // Reference model: lane arrays plus a queue of registers still to be cleared.
    logic [LANE_W-1:0] mem [NREGS][LANES];
    int                clr_q [$];
    bit                m_done;

    always @(negedge clock or negedge async_reset) begin
        if (!async_reset) begin
            for (int r = 0; r < NREGS; r++)
                for (int l = 0; l < LANES; l++) mem[r][l] = '0;
            clr_q.delete();
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (clr_q.size() != 0) begin
                int r;
                r = clr_q.pop_front();
                for (int l = 0; l < LANES; l++) mem[r][l] = '0;
                if (clr_q.size() == 0) m_done = 1'b1;
            end else if (clear_req) begin
                for (int r = 1; r < NREGS; r++) clr_q.push_back(r);
            end else if (write_enable && write_addr != 0 && int'(write_addr) < NREGS) begin
                for (int l = 0; l < LANES; l++)
                    if (write_mask[l])
                        mem[write_addr][l] = write_broadcast ? write_data[LANE_W-1:0]
                                                             : write_data[l*LANE_W +: LANE_W];
            end
        end
    end

    function automatic logic [REG_W-1:0] exp_read(input int addr);
        logic [REG_W-1:0] v;
        v = '0;
        if (addr != 0 && addr < NREGS)
            for (int l = 0; l < LANES; l++) v[l*LANE_W +: LANE_W] = mem[addr][l];
        return v;
    endfunction

    task automatic chk(input string name, input logic [REG_W-1:0] act, input logic [REG_W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(posedge clock) begin
        #1;
        if (check_on) begin
            for (int p = 0; p < NREAD; p++)
                chk($sformatf("rd%0d", p), read_data[p*REG_W +: REG_W],
                    exp_read(int'(read_addr[p*AW +: AW])));
            chk("busy", REG_W'(busy), REG_W'(clr_q.size() != 0));
            chk("clear_done", REG_W'(clear_done), REG_W'(m_done));
            chk("write_dropped", REG_W'(write_dropped),
                REG_W'(write_enable && (clr_q.size() != 0 || clear_req)));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_rd(input int a0, input int a1);
        read_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic do_write(input int addr, input logic [LANES-1:0] mask, input logic bc,
                            input logic [REG_W-1:0] data);
        write_enable    = 1'b1;
        write_addr      = AW'(addr);
        write_mask      = mask;
        write_broadcast = bc;
        write_data      = data;
        tick();
        write_enable    = 1'b0;
        write_mask      = '0;
        write_broadcast = 1'b0;
    endtask

    function automatic logic [REG_W-1:0] fill_val(input int r);
        return {32'(r + 'h300), 32'(r + 'h200), 32'(r + 'h100), 32'(r)};
    endfunction

    // mode 1: mid-sequence spot checks; mode 2: writes attempted during the clear.
    task automatic run_clear(input int mode, output int bc, output int dc);
        clear_req = 1'b1;
        if (mode == 2) begin
            write_enable = 1'b1;
            write_addr   = AW'(9);
            write_mask   = '1;
            write_data   = {4{32'hDEAD_BEEF}};
            #1;
            chk("drop_same_edge", REG_W'(write_dropped), REG_W'(1));
        end
        tick();
        clear_req    = 1'b0;
        write_enable = 1'b0;
        bc = 0;
        dc = 0;
        for (int i = 0; i < 60; i++) begin
            write_enable = 1'b0;
            if (mode == 1 && i == 5) begin
                set_rd(3, 20);
                #1;
                chk("mid_r3_zero", read_data[0 +: REG_W], '0);
                chk("mid_r20_kept", read_data[REG_W +: REG_W], 128'h00000314_00000214_00000114_00000014);
            end
            if (mode == 2 && (i == 2 || i == 20)) begin
                write_enable = 1'b1;
                write_addr   = AW'(i == 2 ? 12 : 5);
                write_mask   = '1;
                write_data   = {4{32'h1234_5678}};
                #1;
                chk("drop_busy", REG_W'(write_dropped), REG_W'(1));
            end
            if (busy) bc++;
            if (clear_done) dc++;
            tick();
        end
        write_enable = 1'b0;
    endtask

    initial begin
        int bc, dc;
        async_reset = 1'b1; write_enable = 1'b0; write_addr = '0; write_mask = '0;
        write_broadcast = 1'b0; write_data = '0; read_addr = '0; clear_req = 1'b0;
        #1 async_reset = 1'b0;
        check_on = 1'b1;
        tick();
        set_rd(5, 0);
        #1;
        chk("rst_rd5", read_data[0 +: REG_W], '0);
        chk("rst_busy", REG_W'(busy), '0);
        chk("rst_done", REG_W'(clear_done), '0);
        tick();
        async_reset = 1'b1;
        tick();

        // Full-mask write.
        do_write(5, 4'b1111, 1'b0, {32'hD, 32'hC, 32'hB, 32'hA});
        set_rd(5, 0);
        #1;
        chk("t1_model", exp_read(5), 128'h0000000D_0000000C_0000000B_0000000A);
        chk("t1_p0", read_data[0 +: REG_W], 128'h0000000D_0000000C_0000000B_0000000A);
        chk("t1_p1_zero", read_data[REG_W +: REG_W], '0);
        tick();

        // Partial mask.
        do_write(5, 4'b0101, 1'b0, {32'h4, 32'h3, 32'h2, 32'h1});
        set_rd(0, 5);
        #1;
        chk("t2_model", exp_read(5), 128'h0000000D_00000003_0000000B_00000001);
        chk("t2_p1", read_data[REG_W +: REG_W], 128'h0000000D_00000003_0000000B_00000001);
        tick();

        // Broadcast into lanes 1..3, lane 0 untouched.
        do_write(7, 4'b1111, 1'b0, {32'h4, 32'h3, 32'h2, 32'h77});
        do_write(7, 4'b1110, 1'b1, {32'hEE, 32'hEE, 32'hEE, 32'h55});
        set_rd(7, 5);
        #1;
        chk("t3_model", exp_read(7), 128'h00000055_00000055_00000055_00000077);
        chk("t3_p0", read_data[0 +: REG_W], 128'h00000055_00000055_00000055_00000077);
        tick();

        // Write to register 0 is discarded without write_dropped.
        write_enable = 1'b1; write_addr = '0; write_mask = '1; write_data = '1;
        #1;
        chk("w0_not_dropped", REG_W'(write_dropped), '0);
        tick();
        write_enable = 1'b0;
        set_rd(0, 0);
        #1;
        chk("w0_reads_zero", read_data[0 +: REG_W], '0);
        tick();

        // Fill and bulk clear.
        for (int r = 1; r < NREGS; r++) do_write(r, 4'b1111, 1'b0, fill_val(r));
        set_rd(31, 20);
        #1;
        chk("fill_r31", read_data[0 +: REG_W], 128'h0000031F_0000021F_0000011F_0000001F);
        run_clear(1, bc, dc);
        chk("t4_busy_cycles", REG_W'(bc), REG_W'(31));
        chk("t4_done_cycles", REG_W'(dc), REG_W'(1));
        for (int r = 1; r < NREGS; r++) begin
            set_rd(r, NREGS - r);
            #1;
            chk("t4_cleared", read_data[0 +: REG_W], '0);
            tick();
        end

        // Dropped writes: same edge as clear_req, and during busy.
        do_write(9, 4'b1111, 1'b0, fill_val(9));
        run_clear(2, bc, dc);
        chk("t5_busy_cycles", REG_W'(bc), REG_W'(31));
        set_rd(9, 12);
        #1;
        chk("t5_r9_zero", read_data[0 +: REG_W], '0);
        chk("t5_r12_zero", read_data[REG_W +: REG_W], '0);
        tick();
        set_rd(5, 0);
        #1;
        chk("t5_r5_zero", read_data[0 +: REG_W], '0);
        tick();

        // Reset during the clear sequence.
        do_write(25, 4'b1111, 1'b0, fill_val(25));
        do_write(30, 4'b1111, 1'b0, fill_val(30));
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        set_rd(25, 30);
        #1;
        chk("t6_r25_before", read_data[0 +: REG_W], fill_val(25));
        async_reset = 1'b0;
        #1;
        chk("t6_busy_drop", REG_W'(busy), '0);
        chk("t6_r25_zero", read_data[0 +: REG_W], '0);
        chk("t6_r30_zero", read_data[REG_W +: REG_W], '0);
        tick();
        async_reset = 1'b1;
        tick();
        do_write(4, 4'b0011, 1'b0, fill_val(4));
        run_clear(0, bc, dc);
        chk("t6_busy_cycles", REG_W'(bc), REG_W'(31));
        chk("t6_done_cycles", REG_W'(dc), REG_W'(1));
        set_rd(4, 0);
        #1;
        chk("t6_r4_zero", read_data[0 +: REG_W], '0);
        tick();

        check_on = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
